// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
// The FSM state, grant owner and default abort threshold live here.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter muxing instruction fetch and load/store onto one memory port.
// Latency: grant 1 cycle, strobes until waitrequest drops, ready pulse 1 cycle later; requesters hold until ready.
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_ready,
    output logic [31:0] instr_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        stall,
    output logic        bus_error
);

    // Abort fires on the wait edge that brings the count to TIMEOUT_CYCLES.
    localparam logic [31:0] LP_LAST_WAIT =
        (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    bus_state_t  r_state;
    bus_state_t  w_state_nxt;
    grant_t      r_last_grant;
    grant_t      w_grant;
    logic        w_grant_en;
    logic        w_done;
    logic        w_timeout;
    logic        w_data_pend;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_is_write;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;
    logic        r_bus_error;

    assign w_data_pend = data_read | data_write;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant        = r_last_grant;
        w_grant_en     = 1'b0;
        w_done         = 1'b0;
        w_timeout      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        instr_ready    = 1'b0;
        data_ready     = 1'b0;

        case (r_state)
            IDLE: begin
                if (instr_req && w_data_pend) begin
                    w_grant    = (r_last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
                    w_grant_en = 1'b1;
                end else if (instr_req) begin
                    w_grant    = GRANT_INSTR;
                    w_grant_en = 1'b1;
                end else if (w_data_pend) begin
                    w_grant    = GRANT_DATA;
                    w_grant_en = 1'b1;
                end
                if (w_grant_en) begin
                    w_state_nxt = (w_grant == GRANT_DATA) ? DATA : INSTR;
                end
            end
            INSTR, DATA: begin
                mem_read  = (r_state == INSTR) || !r_is_write;
                mem_write = (r_state == DATA) && r_is_write;
                if (!mem_waitrequest) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_wait_cnt >= LP_LAST_WAIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // The owner of the finished access is always the last grant.
                instr_ready = (r_last_grant == GRANT_INSTR);
                data_ready  = (r_last_grant == GRANT_DATA);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_INSTR;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_be          <= 4'h0;
            r_is_write    <= 1'b0;
            r_wait_cnt    <= 32'h0;
            r_instr_rdata <= 32'h0;
            r_data_rdata  <= 32'h0;
            r_bus_error   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_en) begin
                r_last_grant <= w_grant;
                if (w_grant == GRANT_DATA) begin
                    r_addr     <= data_addr;
                    r_wdata    <= data_writedata;
                    r_be       <= data_byteenable;
                    r_is_write <= data_write;
                    if (data_read && data_write) begin
                        r_bus_error <= 1'b1;
                    end
                end else begin
                    r_addr     <= instr_addr;
                    r_wdata    <= 32'h0;
                    r_be       <= 4'hF;
                    r_is_write <= 1'b0;
                end
            end

            if ((r_state == INSTR || r_state == DATA) && mem_waitrequest && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end else begin
                r_wait_cnt <= 32'h0;
            end

            // Stores never touch the load data register, even on abort.
            if (w_done || w_timeout) begin
                if (r_state == INSTR) begin
                    r_instr_rdata <= w_done ? mem_readdata : 32'h0;
                end else if (!r_is_write) begin
                    r_data_rdata <= w_done ? mem_readdata : 32'h0;
                end
            end

            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign mem_address    = r_addr;
    assign mem_writedata  = r_wdata;
    assign mem_byteenable = r_be;
    assign instr_rdata    = r_instr_rdata;
    assign data_rdata     = r_data_rdata;
    assign bus_error      = r_bus_error;
    assign stall          = (instr_req && !instr_ready) || (w_data_pend && !data_ready);

endmodule
